// File: rtl/inside_match_pkg.sv
// Shared sizing and entry payload type for the inside-match stage.
package inside_match_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef struct packed {
      logic             en;
      logic [WIDTH-1:0] val;
   } entry_t;

endpackage

// File: rtl/prio_enc_lo.sv
// Lowest-index priority encoder: reports whether any bit is set and where the lowest one is.
module prio_enc_lo #(
   parameter  int unsigned N     = 8,
   localparam int unsigned IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     vec,
   output logic             any_c,
   output logic [IDX_W-1:0] idx_c
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      any_c = |vec;
      idx_c = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (vec[i]) idx_c = IDX_W'(i);
      end
   end

endmodule

// File: rtl/inside_match_stage.sv
// Two-register pipelined set-membership check against a programmable value table,
// with a saturating count of delivered hits.
module inside_match_stage
   import inside_match_pkg::*;
#(
   parameter  int unsigned WIDTH = inside_match_pkg::WIDTH,
   parameter  int unsigned DEPTH = inside_match_pkg::DEPTH,
   parameter  int unsigned CNT_W = inside_match_pkg::CNT_W,
   localparam int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_addr,
   input  logic [WIDTH-1:0] cfg_data,
   input  logic             cfg_en,
   input  logic             cnt_clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_hit,
   output logic [IDX_W-1:0] out_idx,
   output logic [CNT_W-1:0] hit_count
);

   logic [DEPTH-1:0] entry_en;
   logic [WIDTH-1:0] entry_val [DEPTH];

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;

   logic             stall_c;
   logic [DEPTH-1:0] hit_vec_c;
   logic             any_c;
   logic [IDX_W-1:0] idx_c;

   // Stall only on a held result; never looks at in_valid.
   assign stall_c  = out_valid & ~out_ready;
   assign in_ready = ~stall_c;

   // Table write port; disabled entries keep a defined value so compares never see X.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         entry_en <= '0;
         for (int i = 0; i < int'(DEPTH); i++) entry_val[i] <= '0;
      end else if (cfg_we) begin
         entry_en[cfg_addr]  <= cfg_en;
         entry_val[cfg_addr] <= cfg_data;
      end
   end

   // Compare the S1 sample against every enabled entry using the current table.
   always_comb begin
      hit_vec_c = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         hit_vec_c[i] = entry_en[i] & (entry_val[i] == s1_data);
      end
   end

   prio_enc_lo #(.N(DEPTH)) u_prio (
      .vec   (hit_vec_c),
      .any_c (any_c),
      .idx_c (idx_c)
   );

   // S1 capture; holds while the output is stalled.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (!stall_c) begin
         s1_valid <= in_valid;
         if (in_valid) s1_data <= in_data;
      end
   end

   // Output register; a stalled S1 sample keeps re-comparing until it moves here.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         out_valid <= 1'b0;
         out_hit   <= 1'b0;
         out_idx   <= '0;
      end else if (!stall_c) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_hit <= any_c;
            out_idx <= idx_c;
         end
      end
   end

   // Saturating hit counter; a clear beats a coincident increment.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hit_count <= '0;
      end else if (cnt_clr) begin
         hit_count <= '0;
      end else if (out_valid && out_ready && out_hit && (hit_count != {CNT_W{1'b1}})) begin
         hit_count <= hit_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_inside_match_stage.sv
// Scoreboard bench for inside_match_stage: the driver queues hand-computed results,
// a negedge monitor pops and compares them on every output handshake.
module tb_inside_match_stage;

   localparam int unsigned CW = 4;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       cfg_we = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       cfg_en = 1'b0;
   logic       cnt_clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic       out_hit;
   logic [2:0] out_idx;
   logic [CW-1:0] hit_count;

   inside_match_stage #(.WIDTH(8), .DEPTH(8), .CNT_W(CW)) dut (
      .clk       (clk),
      .clr       (clr),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_en    (cfg_en),
      .cnt_clr   (cnt_clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_hit   (out_hit),
      .out_idx   (out_idx),
      .hit_count (hit_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       hit;
      logic [2:0] idx;
      int         cyc;
      bit         lat;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [2:0] a, input logic [7:0] d, input logic en);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d; cfg_en = en;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
   endtask

   // Offer one sample; queue its expected result at the edge that accepts it.
   task automatic send(input logic [7:0] d, input logic h, input logic [2:0] ix, input bit lat);
      exp_t e;
      in_valid = 1'b1;
      in_data  = d;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (in_ready) begin
            e.hit = h; e.idx = ix; e.cyc = cyc; e.lat = lat;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      checks++;
      errors++;
      $display("FAIL send_timeout data=%0h actual=not_accepted required=accepted", d);
      in_valid = 1'b0;
   endtask

   // Monitor: pop on every handshake, and hold outputs to account while stalled.
   exp_t       me;
   bit         stall_seen = 1'b0;
   logic       s_hit;
   logic [2:0] s_idx;

   always @(negedge clk) begin
      if (clr) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen)
            check("stall_stable", {out_valid, out_hit, out_idx}, {1'b1, s_hit, s_idx});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result actual=%0b/%0d required=none", out_hit, out_idx);
            end else begin
               me = exp_q.pop_front();
               check("result", {out_hit, out_idx}, {me.hit, me.idx});
               if (me.lat) check("latency", cyc - me.cyc, 2);
            end
         end
         stall_seen = out_valid && !out_ready;
         s_hit = out_hit;
         s_idx = out_idx;
      end
   end

   initial begin
      // Reset state, then a clear that lands on a loaded pipeline.
      idle(3);
      clr = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_hit_count", hit_count, 0);

      cfg(3'd0, 8'h3C, 1'b1);
      send(8'h3C, 1'b1, 3'd0, 1'b0);
      idle(3);
      check("pre_clr_count", hit_count, 1);
      out_ready = 1'b0;
      send(8'h3C, 1'b1, 3'd0, 1'b0);
      send(8'h3C, 1'b1, 3'd0, 1'b0);
      idle(1);
      clr = 1'b1;
      idle(1);
      exp_q.delete();
      check("clr_out_valid", out_valid, 0);
      check("clr_hit_count", hit_count, 0);
      clr = 1'b0;
      out_ready = 1'b1;
      send(8'h3C, 1'b0, 3'd0, 1'b0);
      idle(4);
      check("post_clr_count", hit_count, 0);

      // Basic streaming with latency checks.
      cfg(3'd0, 8'h3C, 1'b1);
      cfg(3'd1, 8'hA5, 1'b1);
      cfg(3'd2, 8'h00, 1'b1);
      send(8'hA5, 1'b1, 3'd1, 1'b1);
      send(8'h3C, 1'b1, 3'd0, 1'b1);
      send(8'h11, 1'b0, 3'd0, 1'b1);
      send(8'h00, 1'b1, 3'd2, 1'b1);
      idle(4);
      check("stream_count", hit_count, 3);

      // Backpressure with three samples offered.
      out_ready = 1'b0;
      fork
         begin
            send(8'hA5, 1'b1, 3'd1, 1'b0);
            send(8'h3C, 1'b1, 3'd0, 1'b0);
            send(8'h00, 1'b1, 3'd2, 1'b0);
         end
         begin
            idle(5);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            out_ready = 1'b1;
         end
      join
      idle(4);
      check("bp_count", hit_count, 6);

      // Duplicate values, then a table write while a sample is stalled in S1.
      cfg(3'd3, 8'h7F, 1'b1);
      cfg(3'd5, 8'h7F, 1'b1);
      send(8'h7F, 1'b1, 3'd3, 1'b0);
      idle(3);
      out_ready = 1'b0;
      send(8'h11, 1'b0, 3'd0, 1'b0);
      send(8'h7F, 1'b1, 3'd5, 1'b0);
      idle(1);
      cfg(3'd3, 8'h7F, 1'b0);
      idle(1);
      check("wif_in_ready", in_ready, 0);
      out_ready = 1'b1;
      idle(4);
      check("wif_count", hit_count, 8);

      // Counter clear, saturation, and clear coincident with a hit handshake.
      cnt_clr = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      check("cnt_clr", hit_count, 0);
      for (int i = 0; i < 14; i++) send(8'h3C, 1'b1, 3'd0, 1'b0);
      idle(4);
      check("cnt_14", hit_count, 14);
      for (int i = 0; i < 3; i++) send(8'h3C, 1'b1, 3'd0, 1'b0);
      idle(4);
      check("cnt_sat", hit_count, 15);
      out_ready = 1'b0;
      send(8'h3C, 1'b1, 3'd0, 1'b0);
      idle(2);
      check("cnt_pre_coinc", hit_count, 15);
      out_ready = 1'b1;
      cnt_clr = 1'b1;
      idle(1);
      cnt_clr = 1'b0;
      check("cnt_coinc_clr", hit_count, 0);

      // Empty table: every random sample misses.
      clr = 1'b1;
      idle(1);
      exp_q.delete();
      clr = 1'b0;
      for (int i = 0; i < 256; i++) send(8'($urandom_range(0, 255)), 1'b0, 3'd0, 1'b0);
      idle(4);
      check("empty_count", hit_count, 0);

      for (int n = 0; n < 100 && exp_q.size() != 0; n++) idle(1);
      check("queue_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
